// File: rtl/mem_stage_ld.sv
// MEM pipeline stage: registers the EX->MEM bus, waits for the data-SRAM read response, then aligns and extends loads.
// Optional build macro MEM_MISALIGN_EXC_EN enables misaligned-access detection on mem_exc.
module mem_stage_ld #(
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int RA_W    = 5,
    parameter int STALL_W = 6,
    parameter int EX_W    = PC_W + 3 + 1 + 4 + 1 + RA_W + DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [STALL_W-1:0]         stall,
    input  logic                       flush,
    input  logic [EX_W-1:0]            ex_to_mem_bus,
    input  logic                       data_sram_rvalid,
    input  logic [DATA_W-1:0]          data_sram_rdata,
    output logic                       mem_stallreq,
    output logic                       mem_exc,
    output logic [2+RA_W+DATA_W-1:0]   mem_to_id,
    output logic [PC_W+1+RA_W+DATA_W-1:0] mem_to_wb_bus
);

    localparam int WADDR_LSB = DATA_W;
    localparam int WE_BIT    = DATA_W + RA_W;
    localparam int WEN_LSB   = WE_BIT + 1;
    localparam int EN_BIT    = WEN_LSB + 4;
    localparam int OP_LSB    = EN_BIT + 1;
    localparam int PC_LSB    = OP_LSB + 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t            state, state_next;
    logic [EX_W-1:0]   ex_reg, ex_next;
    logic              valid_reg, valid_next;
    logic              update;
    logic [31:0]       load_buf;

    logic [PC_W-1:0]   cur_pc;
    logic [2:0]        cur_op, nxt_op;
    logic              cur_en, nxt_en;
    logic [3:0]        cur_wen, nxt_wen;
    logic              cur_we;
    logic [RA_W-1:0]   cur_waddr;
    logic [DATA_W-1:0] cur_res;
    logic [1:0]        cur_a, nxt_a;
    logic              exc_cur, exc_next;
    logic              ld_cur, ld_next;
    logic              data_ok, rf_we_out;
    logic [31:0]       word;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [DATA_W-1:0] load_ext, rf_wdata;
    logic              unused_stall_bits;

    assign unused_stall_bits = ^{stall[STALL_W-1:5], stall[2:0]};

    // Register update priority: flush, then bubble, then capture, otherwise hold.
    always_comb begin
        update     = 1'b1;
        ex_next    = ex_reg;
        valid_next = valid_reg;
        if (flush) begin
            ex_next    = '0;
            valid_next = 1'b0;
        end else if (stall[3] && !stall[4]) begin
            ex_next    = '0;
            valid_next = 1'b0;
        end else if (!stall[3]) begin
            ex_next    = ex_to_mem_bus;
            valid_next = 1'b1;
        end else begin
            update = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg    <= '0;
            valid_reg <= 1'b0;
        end else begin
            ex_reg    <= ex_next;
            valid_reg <= valid_next;
        end
    end

    assign cur_pc    = ex_reg[PC_LSB +: PC_W];
    assign cur_op    = ex_reg[OP_LSB +: 3];
    assign cur_en    = ex_reg[EN_BIT];
    assign cur_wen   = ex_reg[WEN_LSB +: 4];
    assign cur_we    = ex_reg[WE_BIT];
    assign cur_waddr = ex_reg[WADDR_LSB +: RA_W];
    assign cur_res   = ex_reg[DATA_W-1:0];
    assign cur_a     = cur_res[1:0];
    assign nxt_op    = ex_next[OP_LSB +: 3];
    assign nxt_en    = ex_next[EN_BIT];
    assign nxt_wen   = ex_next[WEN_LSB +: 4];
    assign nxt_a     = ex_next[1:0];

`ifdef MEM_MISALIGN_EXC_EN
    // Access size comes from load_op for loads and from the byte enables for stores.
    function automatic logic misaligned(input logic en, input logic [2:0] op,
                                        input logic [3:0] wen, input logic [1:0] a);
        logic half, word_acc;
        if (wen == 4'h0) begin
            half     = (op == 3'd3) || (op == 3'd4);
            word_acc = !((op == 3'd1) || (op == 3'd2) || half);
        end else begin
            half     = (wen == 4'h3) || (wen == 4'hC);
            word_acc = (wen == 4'hF);
        end
        return en && ((half && a[0]) || (word_acc && (a != 2'b00)));
    endfunction

    assign exc_cur  = valid_reg && misaligned(cur_en, cur_op, cur_wen, cur_a);
    assign exc_next = valid_next && misaligned(nxt_en, nxt_op, nxt_wen, nxt_a);
`else
    assign exc_cur  = 1'b0;
    assign exc_next = 1'b0;
`endif

    assign ld_cur  = valid_reg && cur_en && (cur_wen == 4'h0) && !exc_cur;
    assign ld_next = valid_next && nxt_en && (nxt_wen == 4'h0) && !exc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // A response arriving while the register advances is consumed in that same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (update && ld_next) state_next = S_WAIT;
            S_WAIT: begin
                if (data_sram_rvalid) begin
                    if (update) state_next = ld_next ? S_WAIT : S_IDLE;
                    else        state_next = S_DONE;
                end else if (update) begin
                    state_next = S_DRAIN;
                end
            end
            S_DONE:  if (update) state_next = ld_next ? S_WAIT : S_IDLE;
            S_DRAIN: if (data_sram_rvalid) state_next = ld_next ? S_WAIT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       load_buf <= '0;
        else if (state == S_WAIT && data_sram_rvalid)     load_buf <= data_sram_rdata[31:0];
    end

    assign mem_stallreq = ((state == S_WAIT) && !data_sram_rvalid) || (state == S_DRAIN);
    assign mem_exc      = exc_cur;

    // Load alignment and extension
    always_comb begin
        word   = (state == S_DONE) ? load_buf : data_sram_rdata[31:0];
        byte_v = word[{cur_a, 3'b000} +: 8];
        half_v = cur_a[1] ? word[31:16] : word[15:0];
        unique case (cur_op)
            3'd1:    load_ext = DATA_W'($signed(byte_v));
            3'd2:    load_ext = DATA_W'(byte_v);
            3'd3:    load_ext = DATA_W'($signed(half_v));
            3'd4:    load_ext = DATA_W'(half_v);
            default: load_ext = DATA_W'($signed(word));
        endcase
    end

    assign data_ok   = valid_reg && (!ld_cur || ((state == S_WAIT) && data_sram_rvalid) ||
                                     (state == S_DONE));
    assign rf_we_out = cur_we && data_ok && !exc_cur;
    assign rf_wdata  = ld_cur ? load_ext : cur_res;

    assign mem_to_wb_bus = {cur_pc, rf_we_out, cur_waddr, rf_wdata};
    assign mem_to_id     = {data_ok, rf_we_out, cur_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage_ld.sv
// Directed self-checking bench for mem_stage_ld (honours MEM_MISALIGN_EXC_EN if defined).
module tb_mem_stage_ld;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall;
    logic        flush;
    logic [77:0] ex_to_mem_bus;
    logic        data_sram_rvalid;
    logic [31:0] data_sram_rdata;
    logic        mem_stallreq;
    logic        mem_exc;
    logic [38:0] mem_to_id;
    logic [69:0] mem_to_wb_bus;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] HOLD = 6'b011111;

    mem_stage_ld dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .data_sram_rvalid (data_sram_rvalid),
        .data_sram_rdata  (data_sram_rdata),
        .mem_stallreq     (mem_stallreq),
        .mem_exc          (mem_exc),
        .mem_to_id        (mem_to_id),
        .mem_to_wb_bus    (mem_to_wb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [77:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                       input logic en, input logic [3:0] wen,
                                       input logic we, input logic [4:0] waddr,
                                       input logic [31:0] res);
        return {pc, op, en, wen, we, waddr, res};
    endfunction

    function automatic logic [77:0] nop();
        return mk(32'h0, 3'd0, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0);
    endfunction

    // Inputs change 2 time units after the rising edge; outputs are sampled 4 units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 6'b0; flush = 1'b0; ex_to_mem_bus = nop();
        data_sram_rvalid = 1'b0; data_sram_rdata = 32'h0;
        #13;
        checks++; if (mem_stallreq !== 1'b0) begin failures++; $display("[TB] FAIL reset_stallreq got %b want 0", mem_stallreq); end
        checks++; if (mem_exc !== 1'b0) begin failures++; $display("[TB] FAIL reset_exc got %b want 0", mem_exc); end
        checks++; if (mem_to_wb_bus !== 70'h0) begin failures++; $display("[TB] FAIL reset_wb got %h want 0", mem_to_wb_bus); end
        checks++; if (mem_to_id !== 39'h0) begin failures++; $display("[TB] FAIL reset_id got %h want 0", mem_to_id); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        tick();
        ex_to_mem_bus = mk(32'h0000_0010, 3'd0, 1'b0, 4'h0, 1'b1, 5'd3, 32'h1234_5678);
        stall = 6'b0;
        tick();
        ex_to_mem_bus = nop();
        #4;
        checks++; if (mem_to_wb_bus !== {32'h0000_0010, 1'b1, 5'd3, 32'h1234_5678}) begin failures++; $display("[TB] FAIL alu_wb got %h want %h", mem_to_wb_bus, {32'h0000_0010, 1'b1, 5'd3, 32'h1234_5678}); end
        checks++; if (mem_to_id !== {1'b1, 1'b1, 5'd3, 32'h1234_5678}) begin failures++; $display("[TB] FAIL alu_id got %h want %h", mem_to_id, {1'b1, 1'b1, 5'd3, 32'h1234_5678}); end
        checks++; if (mem_stallreq !== 1'b0) begin failures++; $display("[TB] FAIL alu_stallreq got %b want 0", mem_stallreq); end
    endtask

    task automatic test_lw_latency();
        tick();
        ex_to_mem_bus = mk(32'h0000_0040, 3'd0, 1'b1, 4'h0, 1'b1, 5'd5, 32'h0000_0100);
        stall = 6'b0;
        tick();
        ex_to_mem_bus = nop(); stall = HOLD;
        #4;
        checks++; if (mem_stallreq !== 1'b1) begin failures++; $display("[TB] FAIL lw_stall1 got %b want 1", mem_stallreq); end
        checks++; if (mem_to_id[38:37] !== 2'b00) begin failures++; $display("[TB] FAIL lw_pending_ok_we got %b want 00", mem_to_id[38:37]); end
        tick();
        #4;
        checks++; if (mem_stallreq !== 1'b1) begin failures++; $display("[TB] FAIL lw_stall2 got %b want 1", mem_stallreq); end
        tick();
        data_sram_rvalid = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; stall = 6'b0;
        #4;
        checks++; if (mem_stallreq !== 1'b0) begin failures++; $display("[TB] FAIL lw_stall3 got %b want 0", mem_stallreq); end
        checks++; if (mem_to_wb_bus !== {32'h0000_0040, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin failures++; $display("[TB] FAIL lw_wb got %h", mem_to_wb_bus); end
        checks++; if (mem_to_id[38] !== 1'b1) begin failures++; $display("[TB] FAIL lw_data_ok got %b want 1", mem_to_id[38]); end
        tick();
        data_sram_rvalid = 1'b0;
        #4;
        checks++; if (mem_stallreq !== 1'b0 || mem_to_wb_bus !== 70'h0) begin failures++; $display("[TB] FAIL lw_after stallreq=%b wb=%h want 0/0", mem_stallreq, mem_to_wb_bus); end
    endtask

    task automatic test_align();
        logic [2:0]  ops [7];
        logic [1:0]  addrs [7];
        logic [31:0] exps [7];
        ops = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd1, 3'd2, 3'd3};
        addrs = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        exps = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF,
                 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        for (int i = 0; i < 7; i++) begin
            tick();
            ex_to_mem_bus = mk(32'h0000_0200, ops[i], 1'b1, 4'h0, 1'b1, 5'd9, {30'h0, addrs[i]});
            stall = 6'b0;
            tick();
            ex_to_mem_bus = nop(); data_sram_rvalid = 1'b1; data_sram_rdata = 32'h80FF_0000;
            #4;
            checks++; if (mem_to_wb_bus[31:0] !== exps[i] || mem_to_wb_bus[37] !== 1'b1) begin failures++; $display("[TB] FAIL align_%0d got %h we=%b want %h we=1", i, mem_to_wb_bus[31:0], mem_to_wb_bus[37], exps[i]); end
            tick();
            data_sram_rvalid = 1'b0;
        end
    endtask

    task automatic test_done_hold();
        tick();
        ex_to_mem_bus = mk(32'h0000_0300, 3'd0, 1'b1, 4'h0, 1'b1, 5'd6, 32'h0000_0008);
        stall = 6'b0;
        tick();
        ex_to_mem_bus = nop(); stall = HOLD; data_sram_rvalid = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        #4;
        checks++; if (mem_to_wb_bus[31:0] !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL done_first got %h want deadbeef", mem_to_wb_bus[31:0]); end
        tick();
        data_sram_rvalid = 1'b0; data_sram_rdata = 32'h0;
        #4;
        checks++; if (mem_to_wb_bus !== {32'h0000_0300, 1'b1, 5'd6, 32'hDEAD_BEEF} || mem_stallreq !== 1'b0) begin failures++; $display("[TB] FAIL done_hold wb=%h stallreq=%b", mem_to_wb_bus, mem_stallreq); end
        tick();
        data_sram_rvalid = 1'b1; data_sram_rdata = 32'h1234_5678;
        #4;
        checks++; if (mem_to_wb_bus[31:0] !== 32'hDEAD_BEEF || mem_to_id[38] !== 1'b1) begin failures++; $display("[TB] FAIL done_ignore got %h ok=%b want deadbeef ok=1", mem_to_wb_bus[31:0], mem_to_id[38]); end
        tick();
        data_sram_rvalid = 1'b0; stall = 6'b0;
        tick();
        #4;
        checks++; if (mem_stallreq !== 1'b0 || mem_to_wb_bus !== 70'h0) begin failures++; $display("[TB] FAIL done_release stallreq=%b wb=%h want 0/0", mem_stallreq, mem_to_wb_bus); end
    endtask

    task automatic test_flush_drain();
        tick();
        ex_to_mem_bus = mk(32'h0000_0070, 3'd0, 1'b1, 4'h0, 1'b1, 5'd7, 32'h0000_0010);
        stall = 6'b0;
        tick();
        flush = 1'b1;
        ex_to_mem_bus = mk(32'h0000_0080, 3'd0, 1'b1, 4'h0, 1'b1, 5'd8, 32'h0000_0020);
        #4;
        checks++; if (mem_stallreq !== 1'b1) begin failures++; $display("[TB] FAIL drain_wait got %b want 1", mem_stallreq); end
        tick();
        flush = 1'b0;
        #4;
        checks++; if (mem_stallreq !== 1'b1 || mem_to_wb_bus[37] !== 1'b0) begin failures++; $display("[TB] FAIL drain_bubble stallreq=%b we=%b want 1/0", mem_stallreq, mem_to_wb_bus[37]); end
        tick();
        ex_to_mem_bus = nop(); stall = HOLD;
        #4;
        checks++; if (mem_stallreq !== 1'b1 || mem_to_id[38] !== 1'b0) begin failures++; $display("[TB] FAIL drain_newload stallreq=%b ok=%b want 1/0", mem_stallreq, mem_to_id[38]); end
        tick();
        data_sram_rvalid = 1'b1; data_sram_rdata = 32'h1111_1111;
        #4;
        checks++; if (mem_stallreq !== 1'b1 || mem_to_wb_bus[37] !== 1'b0) begin failures++; $display("[TB] FAIL drain_discard stallreq=%b we=%b want 1/0", mem_stallreq, mem_to_wb_bus[37]); end
        tick();
        data_sram_rvalid = 1'b0;
        #4;
        checks++; if (mem_stallreq !== 1'b1) begin failures++; $display("[TB] FAIL drain_rewait got %b want 1", mem_stallreq); end
        tick();
        data_sram_rvalid = 1'b1; data_sram_rdata = 32'h2222_2222; stall = 6'b0;
        #4;
        checks++; if (mem_to_wb_bus !== {32'h0000_0080, 1'b1, 5'd8, 32'h2222_2222} || mem_stallreq !== 1'b0) begin failures++; $display("[TB] FAIL drain_second wb=%h stallreq=%b", mem_to_wb_bus, mem_stallreq); end
        tick();
        data_sram_rvalid = 1'b0;
    endtask

    task automatic test_misalign();
        tick();
        ex_to_mem_bus = mk(32'h0000_0400, 3'd3, 1'b1, 4'h0, 1'b1, 5'd4, 32'h0000_0001);
        stall = 6'b0;
        tick();
        ex_to_mem_bus = nop();
        data_sram_rdata = 32'h0000_8001;
        #4;
`ifdef MEM_MISALIGN_EXC_EN
        checks++; if (mem_exc !== 1'b1 || mem_to_wb_bus[37] !== 1'b0 || mem_stallreq !== 1'b0) begin failures++; $display("[TB] FAIL misalign_exc exc=%b we=%b stallreq=%b want 1/0/0", mem_exc, mem_to_wb_bus[37], mem_stallreq); end
`else
        checks++; if (mem_exc !== 1'b0 || mem_stallreq !== 1'b1) begin failures++; $display("[TB] FAIL misalign_wait exc=%b stallreq=%b want 0/1", mem_exc, mem_stallreq); end
        stall = HOLD;
        tick();
        data_sram_rvalid = 1'b1; stall = 6'b0;
        #4;
        checks++; if (mem_to_wb_bus[31:0] !== 32'hFFFF_8001 || mem_to_wb_bus[37] !== 1'b1) begin failures++; $display("[TB] FAIL misalign_data got %h we=%b want ffff8001 we=1", mem_to_wb_bus[31:0], mem_to_wb_bus[37]); end
`endif
        tick();
        data_sram_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw_latency();
        test_align();
        test_done_hold();
        test_flush_drain();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
